systolic_skew_feeder: RTL and testbench

- Input stage directly upstream of the SIZE x SIZE weight-stationary systolic array.
- Buffers one full SIZE x SIZE signed activation matrix, received one row per handshake.
- On start, replays the matrix as a diagonally skewed wavefront: lane i is delayed i cycles relative to lane 0, which is the operand timing the array's row inputs expect.
- Signals done once the last wavefront has been issued.

---
 rtl/systolic_skew_feeder.sv | 102 ++++++++++
 tb/tb_systolic_skew_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Activation feeder for a SIZE x SIZE weight-stationary systolic array.
// Buffers one matrix row by row, then replays it as a skewed wavefront (lane i lags lane 0 by i cycles).
//
// state | meaning
// LOAD  | accepting rows into the buffer, in_ready high
// FULL  | matrix complete, waiting for start
// FEED  | issuing wavefronts t = 0 .. 2*SIZE-2
// DONE  | one-cycle wrap-up, done pulse registered, back to LOAD
module systolic_skew_feeder #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SIZE*WIDTH-1:0]   in_row,
    input  logic                    start,
    output logic                    busy,
    output logic [SIZE*WIDTH-1:0]   feed_data,
    output logic [SIZE-1:0]         feed_valid,
    output logic                    done
);
    localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int WW = (SIZE > 1) ? $clog2(2*SIZE-1) : 1;

    typedef enum logic [1:0] {LOAD, FULL, FEED, DONE} state_t;

    state_t              state, state_nxt;
    logic [RW-1:0]       row_cnt;
    logic [WW-1:0]       wave_cnt;
    logic [WIDTH-1:0]    buffer [SIZE][SIZE];
    logic [SIZE*WIDTH-1:0] lane_nxt;
    logic [SIZE-1:0]     valid_nxt;
    logic                row_last, wave_last;

    assign row_last  = (row_cnt == RW'(SIZE-1));
    assign wave_last = (wave_cnt == WW'(2*SIZE-2));
    assign in_ready  = (state == LOAD);

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_valid && row_last) state_nxt = FULL;
            FULL:    if (start) state_nxt = FEED;
            FEED:    if (wave_last) state_nxt = DONE;
            DONE:    state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Lane i shows column t-i of row i while that column exists, else an idle zero.
    always_comb begin
        lane_nxt  = '0;
        valid_nxt = '0;
        if (state == FEED) begin
            for (int i = 0; i < SIZE; i++) begin
                if (int'(wave_cnt) >= i && int'(wave_cnt) - i < SIZE) begin
                    valid_nxt[i]               = 1'b1;
                    lane_nxt[i*WIDTH +: WIDTH] = buffer[i][RW'(int'(wave_cnt) - i)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            row_cnt    <= '0;
            wave_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            feed_data  <= '0;
            feed_valid <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt == FEED);
            done       <= (state == DONE);
            feed_data  <= lane_nxt;
            feed_valid <= valid_nxt;
            case (state)
                LOAD: if (in_valid && !row_last) row_cnt <= row_cnt + 1'b1;
                FULL: if (start) wave_cnt <= '0;
                FEED: if (!wave_last) wave_cnt <= wave_cnt + 1'b1;
                DONE: row_cnt <= '0;
                default: ;
            endcase
        end
    end

    // Buffer survives DONE; a reload simply overwrites it row by row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    buffer[r][c] <= '0;
        end else if (state == LOAD && in_valid) begin
            for (int c = 0; c < SIZE; c++)
                buffer[row_cnt][c] <= in_row[c*WIDTH +: WIDTH];
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: time-window reference model plus literal spot checks.
module tb_systolic_skew_feeder;
    localparam int W = 16;
    localparam int N = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             start = 1'b0;
    logic [N*W-1:0]   in_row = '0;
    logic             in_ready, busy, done;
    logic [N*W-1:0]   feed_data;
    logic [N-1:0]     feed_valid;

    int vectors = 0;
    int miscompares = 0;
    int printed = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.WIDTH(W), .SIZE(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .start(start), .busy(busy),
        .feed_data(feed_data), .feed_valid(feed_valid), .done(done)
    );

    // Reference: rows stored so far, edge at which start was taken, edge of the done pulse.
    int         cyc = 0;
    int         m_rows = 0;
    int         m_feed_k = -1;
    int         m_done_at = -1;
    logic [W-1:0] m_mat [N][N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rows    = 0;
            m_feed_k  = -1;
            m_done_at = -1;
        end else begin
            cyc++;
            if (m_feed_k >= 0 && cyc == m_feed_k + 2*N) begin
                m_feed_k  = -1;
                m_rows    = 0;
                m_done_at = cyc;
            end else if (m_rows == N && m_feed_k < 0 && start) begin
                m_feed_k = cyc;
            end else if (m_rows < N && in_valid) begin
                for (int j = 0; j < N; j++) m_mat[m_rows][j] = in_row[j*W +: W];
                m_rows++;
            end
        end
    end

    always @(negedge clk) begin
        logic [N*W-1:0] ed;
        logic [N-1:0]   ev;
        logic           eb, edn, er;
        int             t;
        ed  = '0;
        ev  = '0;
        eb  = (m_feed_k >= 0 && cyc <= m_feed_k + 2*N - 2);
        edn = (m_done_at >= 0 && cyc == m_done_at);
        er  = (m_rows < N);
        if (m_feed_k >= 0 && cyc >= m_feed_k + 1 && cyc <= m_feed_k + 2*N - 1) begin
            t = cyc - m_feed_k - 1;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    ev[i]         = 1'b1;
                    ed[i*W +: W]  = m_mat[i][t-i];
                end
            end
        end
        vectors++;
        if ({in_ready, busy, done, feed_valid, feed_data} !== {er, eb, edn, ev, ed}) begin
            miscompares++;
            if (printed < 40) begin
                printed++;
                $display("FAIL cycle_%0d: got ready=%b busy=%b done=%b valid=%b data=%h ; want ready=%b busy=%b done=%b valid=%b data=%h",
                         cyc, in_ready, busy, done, feed_valid, feed_data, er, eb, edn, ev, ed);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] elem(input int kind, input int i, input int j);
        if (kind == 0) return W'(10*i + j);
        if (kind == 1) return W'(1000 + 7*i + j);
        if (i == 0) begin
            if (j == 0) return 16'h8000;
            if (j == 1) return 16'hFFFF;
            if (j == 2) return 16'h7FFF;
            return 16'h0000;
        end
        return W'(-(10*i + j));
    endfunction

    function automatic logic [31:0] lane(input int i);
        return 32'(feed_data[i*W +: W]);
    endfunction

    task automatic load_rows(input int kind, input int from, input int upto, input bit gaps);
        int guard;
        for (int i = from; i <= upto; i++) begin
            for (int j = 0; j < N; j++) in_row[j*W +: W] = elem(kind, i, j);
            in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 100) begin
                step(1);
                guard++;
            end
            if (guard >= 100) chk("load_timeout", 32'd1, 32'd0);
            step(1);
            if (gaps) begin
                in_valid = 1'b0;
                step(1);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // 1: reset values before any clock edge, then async clear out of FULL
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(feed_valid), 32'd0);
        chk("rst_data_nz", 32'(feed_data != '0), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);
        load_rows(0, 0, 9, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_in_ready", 32'(in_ready), 32'd1);
        step(1);
        rst = 1'b0;
        step(1);

        // 2: back-to-back load of 10*i+j, then feed with literal spot checks
        load_rows(0, 0, 9, 1'b0);
        chk("t2_ready_drop", 32'(in_ready), 32'd0);
        step(1);
        pulse_start();
        step(1);
        chk("t0_lane0", lane(0), 32'd0);
        chk("t0_valid", 32'(feed_valid), 32'h001);
        chk("t0_busy", 32'(busy), 32'd1);
        step(5);
        chk("t5_lane3", lane(3), 32'd32);
        chk("t5_lane5", lane(5), 32'd50);
        chk("t5_lane6_valid", 32'(feed_valid[6]), 32'd0);
        step(4);
        chk("t9_lane9", lane(9), 32'd90);
        chk("t9_valid", 32'(feed_valid), 32'h3FF);
        step(9);
        chk("t18_valid", 32'(feed_valid), 32'h200);
        chk("t18_lane9", lane(9), 32'd99);
        chk("t18_done", 32'(done), 32'd0);
        step(1);
        chk("k20_done", 32'(done), 32'd1);
        chk("k20_valid", 32'(feed_valid), 32'd0);
        step(2);

        // 3: gapped load, extra row offered in FULL must be refused
        load_rows(1, 0, 9, 1'b1);
        in_row = {N{16'h5A5A}};
        in_valid = 1'b1;
        step(3);
        chk("full_refuses", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        pulse_start();
        step(21);

        // 4: start ignored with a partial matrix and while feeding
        load_rows(0, 0, 3, 1'b0);
        pulse_start();
        chk("partial_busy", 32'(busy), 32'd0);
        step(2);
        chk("partial_busy2", 32'(busy), 32'd0);
        chk("partial_ready", 32'(in_ready), 32'd1);
        load_rows(0, 4, 9, 1'b0);
        step(1);
        pulse_start();
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(15);
        chk("t4_done_early", 32'(done), 32'd0);
        step(1);
        chk("t4_done", 32'(done), 32'd1);
        step(2);

        // 5: reset in the middle of a feed, then a clean rerun
        load_rows(1, 0, 9, 1'b0);
        pulse_start();
        step(8);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(feed_valid), 32'd0);
        chk("midrst_data_nz", 32'(feed_data != '0), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        step(2);
        rst = 1'b0;
        step(25);
        load_rows(0, 0, 9, 1'b0);
        pulse_start();
        step(21);

        // 6: signed extremes, then a second matrix right after done
        load_rows(2, 0, 9, 1'b0);
        pulse_start();
        step(1);
        chk("neg_t0_lane0", lane(0), 32'h8000);
        step(1);
        chk("neg_t1_lane0", lane(0), 32'hFFFF);
        chk("neg_t1_lane1", lane(1), 32'hFFF6);
        step(1);
        chk("neg_t2_lane0", lane(0), 32'h7FFF);
        step(17);
        chk("neg_done", 32'(done), 32'd1);
        load_rows(0, 0, 9, 1'b0);
        pulse_start();
        step(19);
        chk("b2b_lane9", lane(9), 32'd99);
        step(1);
        chk("b2b_done", 32'(done), 32'd1);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
